// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch slice.
package fetch_pkg;

  localparam int FETCH_INSTR_W    = 32;
  localparam int FETCH_NUM_INSTRS = 512;
  localparam int FETCH_ADDR_W     = $clog2(FETCH_NUM_INSTRS);

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [31:0] pc_wrap_inc(
    input logic [31:0] pc,
    input logic [31:0] depth
  );
    return (pc >= depth - 32'd1) ? 32'd0 : pc + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch-to-decode valid/ready handshake.
interface fetch_ctrl_if
  import fetch_pkg::*;
#(
  parameter int INSTR_W = FETCH_INSTR_W,
  parameter int ADDR_W  = FETCH_ADDR_W
);

  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_buf.sv
// Two-entry (output + skid) fetch buffer with push, pop and flush.
module fetch_buf
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  entry_t     i_push_data,
  input  logic       i_ready,
  output logic       o_valid,
  output entry_t     o_data,
  output logic [1:0] o_occ
);

  logic   r_out_valid;
  logic   r_skid_valid;
  entry_t r_out;
  entry_t r_skid;
  logic   w_pop;
  logic   w_out_free;

  assign w_pop      = r_out_valid && i_ready;
  assign w_out_free = !r_out_valid || w_pop;

  // Skid always refills the output before a new return does.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out        <= '0;
      r_skid       <= '0;
    end else if (i_flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out        <= r_skid;
        r_skid_valid <= i_push;
        if (i_push)
          r_skid <= i_push_data;
      end else begin
        r_out_valid <= i_push;
        if (i_push)
          r_out <= i_push_data;
      end
    end else if (i_push) begin
      r_skid_valid <= 1'b1;
      r_skid       <= i_push_data;
    end
  end

  assign o_valid = r_out_valid;
  assign o_data  = r_out;
  assign o_occ   = {1'b0, r_out_valid} + {1'b0, r_skid_valid};

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: PC, read issue and return tracking for a 1-cycle imem.
// Optional perf counters enabled by defining FETCH_CTRL_PERF_EN.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int INSTR_W    = FETCH_INSTR_W,
  parameter int NUM_INSTRS = FETCH_NUM_INSTRS,
  parameter int ADDR_W     = $clog2(NUM_INSTRS),
  parameter int RESET_PC   = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_en,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_addr,
  fetch_ctrl_if.master       out_if
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stall
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_req_valid;
  logic              w_pop;
  logic              w_issue;
  logic [1:0]        w_occ;
  logic [2:0]        w_pending;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_redir_pc;
  logic              w_head_valid;
  entry_t            w_ret;
  entry_t            w_head;

  assign w_pop     = w_head_valid && out_if.out_ready;
  // Issue only when every outstanding word still has a slot.
  assign w_pending = 3'(w_occ) + 3'(r_req_valid) - 3'(w_pop);
  assign w_issue   = fetch_en && !redirect_valid &&
                     (w_pending <= 3'd1);

  assign w_pc_inc   = ADDR_W'(pc_wrap_inc(32'(r_pc),
                                          32'(NUM_INSTRS)));
  assign w_redir_pc = (32'(redirect_addr) >= 32'(NUM_INSTRS)) ?
                      '0 : redirect_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= ADDR_W'(RESET_PC);
      r_req_valid <= 1'b0;
      r_req_pc    <= '0;
    end else if (redirect_valid) begin
      r_pc        <= w_redir_pc;
      r_req_valid <= 1'b0;
    end else begin
      r_req_valid <= w_issue;
      if (w_issue) begin
        r_req_pc <= r_pc;
        r_pc     <= w_pc_inc;
      end
    end
  end

  assign w_ret.pc    = r_req_pc;
  assign w_ret.instr = imem_rdata;

  fetch_buf #(
    .entry_t (entry_t)
  ) u_buf (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (redirect_valid),
    .i_push      (r_req_valid),
    .i_push_data (w_ret),
    .i_ready     (out_if.out_ready),
    .o_valid     (w_head_valid),
    .o_data      (w_head),
    .o_occ       (w_occ)
  );

  assign imem_addr        = r_pc;
  assign out_if.out_valid = w_head_valid;
  assign out_if.out_instr = w_head.instr;
  assign out_if.out_pc    = w_head.pc;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
    end else begin
      if (w_pop)
        r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_head_valid && !out_if.out_ready)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table, directed corners, random vs model.
`timescale 1ns/1ps
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fen, redir;
  logic [AW-1:0] raddr, addr;
  logic [31:0]   rdata;
  logic          fen3, redir3;
  logic [AW-1:0] raddr3, addr3;
  logic [31:0]   rdata3;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0]   pf, ps, pf3, ps3;
`endif

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.INSTR_W(32), .ADDR_W(AW)) oif();
  fetch_ctrl_if #(.INSTR_W(32), .ADDR_W(AW)) oif3();

  fetch_ctrl #(.NUM_INSTRS(512)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fen),
    .imem_addr      (addr),
    .imem_rdata     (rdata),
    .redirect_valid (redir),
    .redirect_addr  (raddr),
    .out_if         (oif)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetched   (pf),
    .perf_stall     (ps)
`endif
  );

  fetch_ctrl #(.NUM_INSTRS(300)) dut300 (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fen3),
    .imem_addr      (addr3),
    .imem_rdata     (rdata3),
    .redirect_valid (redir3),
    .redirect_addr  (raddr3),
    .out_if         (oif3)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .perf_fetched   (pf3),
    .perf_stall     (ps3)
`endif
  );

  // Memory word k holds the value k.
  always @(posedge clk) begin
    rdata  <= 32'(addr);
    rdata3 <= 32'(addr3);
  end

  typedef struct {
    logic          fen;
    logic          rdy;
    logic          redir;
    logic [AW-1:0] raddr;
    logic          ev;
    logic [AW-1:0] epc;
    logic [AW-1:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic f, input logic r, input logic d,
                     input int ra, input logic v, input int p,
                     input int a);
    vec_t t;
    t.fen = f; t.rdy = r; t.redir = d; t.raddr = AW'(ra);
    t.ev = v; t.epc = AW'(p); t.eaddr = AW'(a);
    tbl.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic f, input logic r, input logic d,
                     input int ra);
    @(negedge clk);
    fen = f; oif.out_ready = r; redir = d; raddr = AW'(ra);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc3(input logic f, input logic r, input logic d,
                      input int ra);
    @(negedge clk);
    fen3 = f; oif3.out_ready = r; redir3 = d; raddr3 = AW'(ra);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    fen = 1'b0; oif.out_ready = 1'b1; redir = 1'b0; raddr = '0;
    fen3 = 1'b0; oif3.out_ready = 1'b1; redir3 = 1'b0; raddr3 = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int nxt(input int p);
    return (p + 1) % 512;
  endfunction

  initial begin
    int exp_next, gap, npop, nstall;
    logic          pre_v;
    logic [AW-1:0] pre_pc, pre_a;
    logic [31:0]   pre_i;
    logic          f, r, d;
    int            ra;

    fen = 1'b0; oif.out_ready = 1'b1; redir = 1'b0; raddr = '0;
    fen3 = 1'b0; oif3.out_ready = 1'b1; redir3 = 1'b0; raddr3 = '0;

    // stream, stall at pc 3, redirect with full skid,
    // fetch_en drop at pc 20, wrap 510 -> 0
    add(1,1,0,0,   0,0,1);
    add(1,1,0,0,   1,0,2);
    add(1,1,0,0,   1,1,3);
    add(1,1,0,0,   1,2,4);
    add(1,1,0,0,   1,3,5);
    for (int i = 0; i < 5; i++) add(1,0,0,0, 1,3,5);
    add(1,1,0,0,   1,4,6);
    add(1,1,0,0,   1,5,7);
    add(1,1,0,0,   1,6,8);
    add(1,0,0,0,   1,6,8);
    add(1,0,1,100, 0,0,100);
    add(1,1,0,0,   0,0,101);
    add(1,1,0,0,   1,100,102);
    add(1,1,0,0,   1,101,103);
    add(1,1,0,0,   1,102,104);
    add(1,1,1,18,  0,0,18);
    add(1,1,0,0,   0,0,19);
    add(1,1,0,0,   1,18,20);
    add(0,1,0,0,   1,19,20);
    add(0,1,0,0,   0,0,20);
    add(0,1,0,0,   0,0,20);
    add(1,1,0,0,   0,0,21);
    add(1,1,0,0,   1,20,22);
    add(1,1,0,0,   1,21,23);
    add(1,1,1,510, 0,0,510);
    add(1,1,0,0,   0,0,511);
    add(1,1,0,0,   1,510,0);
    add(1,1,0,0,   1,511,1);
    add(1,1,0,0,   1,0,2);
    add(1,1,0,0,   1,1,3);

    #2;
    chk("rst_valid", 32'(oif.out_valid), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_pc", 32'(oif.out_pc), 0);
    chk("rst_instr", oif.out_instr, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].fen, tbl[i].rdy, tbl[i].redir, 32'(tbl[i].raddr));
      chk($sformatf("vec%0d_valid", i), 32'(oif.out_valid),
          32'(tbl[i].ev));
      chk($sformatf("vec%0d_addr", i), 32'(addr), 32'(tbl[i].eaddr));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_pc", i), 32'(oif.out_pc),
            32'(tbl[i].epc));
        chk($sformatf("vec%0d_instr", i), oif.out_instr,
            32'(tbl[i].epc));
      end
    end

    // Asynchronous reset with the skid full
    cyc(1,0,0,0);
    cyc(1,0,0,0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(oif.out_valid), 0);
    chk("arst_addr", 32'(addr), 0);
    @(negedge clk);
    rst = 1'b0; fen = 1'b1; oif.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("arst_e1_valid", 32'(oif.out_valid), 0);
    @(posedge clk); #1;
    chk("arst_e2_valid", 32'(oif.out_valid), 1);
    chk("arst_e2_pc", 32'(oif.out_pc), 0);

    // NUM_INSTRS=300 wrap and out-of-range redirect
    do_reset();
    cyc3(1,1,1,298);
    chk("w300_redir_addr", 32'(addr3), 298);
    cyc3(1,1,0,0);
    chk("w300_addr299", 32'(addr3), 299);
    cyc3(1,1,0,0);
    chk("w300_pc298", 32'(oif3.out_pc), 298);
    chk("w300_addr_wrap", 32'(addr3), 0);
    cyc3(1,1,0,0);
    chk("w300_pc299", 32'(oif3.out_pc), 299);
    cyc3(1,1,0,0);
    chk("w300_pc0", 32'(oif3.out_pc), 0);
    chk("w300_v0", 32'(oif3.out_valid), 1);
    cyc3(1,1,1,400);
    chk("w300_oor_addr", 32'(addr3), 0);
    chk("w300_oor_valid", 32'(oif3.out_valid), 0);
    cyc3(1,1,0,0);
    cyc3(1,1,0,0);
    chk("w300_oor_pc", 32'(oif3.out_pc), 0);
    chk("w300_oor_v", 32'(oif3.out_valid), 1);

`ifdef FETCH_CTRL_PERF_EN
    do_reset();
    cyc(1,1,0,0);
    cyc(1,1,0,0);
    for (int i = 0; i < 4; i++) cyc(1,0,0,0);
    for (int i = 0; i < 10; i++) cyc(1,1,0,0);
    chk("perf_fetched", pf, 10);
    chk("perf_stall", ps, 4);
`endif

    // Random traffic against an in-order stream model
    do_reset();
    exp_next = 0; gap = 0; npop = 0; nstall = 0;
    for (int n = 0; n < 3000; n++) begin
      f  = ($urandom_range(0, 9) != 0);
      r  = ($urandom_range(0, 9) < 7);
      d  = ($urandom_range(0, 29) == 0);
      ra = int'($urandom_range(0, 511));
      @(negedge clk);
      fen = f; oif.out_ready = r; redir = d; raddr = AW'(ra);
      pre_v  = oif.out_valid;
      pre_pc = oif.out_pc;
      pre_i  = oif.out_instr;
      pre_a  = addr;
      @(posedge clk); #1;
      if (pre_v && r) begin
        npop++;
        chk("rnd_order", 32'(pre_pc), 32'(exp_next));
        chk("rnd_instr", pre_i, 32'(pre_pc));
        exp_next = nxt(int'(pre_pc));
      end
      if (pre_v && !r) begin
        nstall++;
        if (!d) begin
          chk("rnd_hold_v", 32'(oif.out_valid), 1);
          chk("rnd_hold_pc", 32'(oif.out_pc), 32'(pre_pc));
          chk("rnd_hold_i", oif.out_instr, pre_i);
        end
      end
      if (d) begin
        exp_next = ra;
        gap = 0;
        chk("rnd_flush", 32'(oif.out_valid), 0);
      end else if (!f) begin
        gap = 0;
        chk("rnd_pc_hold", 32'(addr), 32'(pre_a));
      end else begin
        gap = oif.out_valid ? 0 : gap + 1;
        chk("rnd_live", 32'(gap <= 2), 1);
      end
    end
`ifdef FETCH_CTRL_PERF_EN
    chk("rnd_perf_fetched", pf, 32'(npop));
    chk("rnd_perf_stall", ps, 32'(nstall));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
